// File: rtl/neuron_learn_layer_seq_pkg.sv
// Shared fixed-point types, limits and saturation helpers for the sequential learning layer.
package neuron_learn_layer_seq_pkg;
  localparam int ZW = 8;
  localparam int FW = 16;
  localparam int F  = FW - 2;
  localparam int WIDE_W = 64;

  typedef logic [ZW-1:0]            zero2one_t;
  typedef logic signed [FW-1:0]     frac_t;
  typedef logic signed [WIDE_W-1:0] wide_t;

  localparam frac_t FRAC_MAX = frac_t'((1 << (FW - 1)) - 1);
  localparam frac_t FRAC_MIN = frac_t'(-(1 << (FW - 1)));

  function automatic frac_t sat_frac(input wide_t x);
    if (x > wide_t'(FRAC_MAX)) return FRAC_MAX;
    if (x < wide_t'(FRAC_MIN)) return FRAC_MIN;
    return x[FW-1:0];
  endfunction

  function automatic zero2one_t clamp_z2o(input wide_t x);
    if (x < 0) return '0;
    if (x > wide_t'((1 << ZW) - 1)) return '1;
    return x[ZW-1:0];
  endfunction
endpackage

// File: rtl/neuron_mac_unit.sv
// Shared signed multiply-accumulate; o_sum already includes the current product.
module neuron_mac_unit
  import neuron_learn_layer_seq_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic                    i_clk,
  input  logic                    i_en,
  input  logic                    i_first,
  input  frac_t                   i_a,
  input  logic signed [ZW:0]      i_b,
  output logic signed [ACC_W-1:0] o_sum
);
  logic signed [ACC_W-1:0] r_acc_p0;
  logic signed [ACC_W-1:0] w_prod;

  assign w_prod = ACC_W'(i_a) * ACC_W'(i_b);
  assign o_sum  = (i_first ? '0 : r_acc_p0) + w_prod;

  // stage p0: running accumulator, restarted by i_first
  always_ff @(posedge i_clk) begin
    if (i_en) r_acc_p0 <= o_sum;
  end
endmodule

// File: rtl/neuron_learn_layer_seq.sv
// M-neuron x N-input learning layer folded onto one MAC: inference, then optional weight update and back-propagation.
module neuron_learn_layer_seq
  import neuron_learn_layer_seq_pkg::*;
#(
  parameter int N        = 16,
  parameter int M        = 8,
  parameter int LR_SHIFT = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   learn,
  input  zero2one_t [N-1:0]                      in,
  input  zero2one_t [M-1:0]                      expected_out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output zero2one_t [M-1:0]                      out,
  output zero2one_t [N-1:0]                      expected_in,
  output frac_t [M-1:0][N-1:0]                   weights,
  output frac_t [M-1:0]                          activation_max,
  output frac_t [M-1:0]                          activation_min,
  input  logic                                   w_wr_en,
  input  logic [((M > 1) ? $clog2(M) : 1)-1:0]   w_wr_row,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]   w_wr_col,
  input  frac_t                                  w_wr_data
);
  localparam int MW    = (M > 1) ? $clog2(M) : 1;
  localparam int NW    = (N > 1) ? $clog2(N) : 1;
  localparam int LOG2M = $clog2(M);
  // Wide enough for both a row sum over N and a back-propagated column sum over M.
  localparam int ACC_W = FW + ZW + $clog2(N) + $clog2(M) + 2;
  localparam int PW    = 2 * ZW + 2;
  localparam int DSH   = 2 * ZW - F + LR_SHIFT;

  typedef enum logic [1:0] {IDLE, MAC, UPDATE, DONE} state_t;

  state_t                r_state;
  logic [MW-1:0]         r_j;
  logic [NW-1:0]         r_i;
  logic                  r_learn;
  logic                  r_out_valid;
  zero2one_t [N-1:0]     r_in;
  zero2one_t [M-1:0]     r_exp;
  zero2one_t [M-1:0]     r_out;
  zero2one_t [N-1:0]     r_exp_in;
  frac_t [M-1:0][N-1:0]  r_w;
  frac_t [M-1:0]         r_amax;
  frac_t [M-1:0]         r_amin;

  logic                    w_last_i, w_last_j, w_first, w_en;
  frac_t                   w_a, w_s, w_w_new;
  logic signed [ZW:0]      w_err, w_in_s, w_b;
  logic signed [PW-1:0]    w_dprod;
  logic signed [ACC_W-1:0] w_sum;
  zero2one_t               w_out_j, w_exp_in_i;

  assign w_last_i = (r_i == NW'(N - 1));
  assign w_last_j = (r_j == MW'(M - 1));
  assign w_a      = r_w[r_j][r_i];
  assign w_in_s   = $signed({1'b0, r_in[r_i]});
  assign w_err    = $signed({1'b0, r_exp[r_j]}) - $signed({1'b0, r_out[r_j]});
  assign w_b      = (r_state == UPDATE) ? w_err : w_in_s;
  // UPDATE walks column-major so the shared accumulator sums bp[i] across neurons.
  assign w_first  = (r_state == UPDATE) ? (r_j == '0) : (r_i == '0);
  assign w_en     = (r_state == MAC) || (r_state == UPDATE);

  neuron_mac_unit #(.ACC_W(ACC_W)) u_mac (
    .i_clk   (clock),
    .i_en    (w_en),
    .i_first (w_first),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_sum   (w_sum)
  );

  assign w_dprod    = PW'(w_err) * PW'(w_in_s);
  assign w_w_new    = sat_frac(wide_t'(w_a) + wide_t'(w_dprod >>> DSH));
  assign w_s        = sat_frac(wide_t'(w_sum >>> ZW));
  assign w_out_j    = clamp_z2o(wide_t'(w_sum >>> F));
  assign w_exp_in_i = clamp_z2o(wide_t'(r_in[r_i]) + wide_t'((w_sum >>> F) >>> LOG2M));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_learn     <= 1'b0;
      r_j         <= '0;
      r_i         <= '0;
      r_w         <= '0;
      r_out       <= '0;
      r_exp_in    <= '0;
      for (int k = 0; k < M; k++) begin
        r_amax[k] <= FRAC_MIN;
        r_amin[k] <= FRAC_MAX;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_en) r_w[w_wr_row][w_wr_col] <= w_wr_data;
          if (in_valid) begin
            r_in    <= in;
            r_exp   <= expected_out;
            r_learn <= learn;
            r_j     <= '0;
            r_i     <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          if (w_last_i) begin
            r_out[r_j] <= w_out_j;
            if (w_s > r_amax[r_j]) r_amax[r_j] <= w_s;
            if (w_s < r_amin[r_j]) r_amin[r_j] <= w_s;
            r_i <= '0;
            if (w_last_j) begin
              r_j <= '0;
              if (r_learn) begin
                r_state <= UPDATE;
              end else begin
                r_exp_in <= r_in;
                r_state  <= DONE;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        UPDATE: begin
          r_w[r_j][r_i] <= w_w_new;
          if (w_last_j) begin
            r_exp_in[r_i] <= w_exp_in_i;
            r_j <= '0;
            if (w_last_i) begin
              r_i     <= '0;
              r_state <= DONE;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle only raises out_valid; the handshake is honoured from then on.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready       = (r_state == IDLE);
  assign out_valid      = r_out_valid;
  assign out            = r_out;
  assign expected_in    = r_exp_in;
  assign weights        = r_w;
  assign activation_max = r_amax;
  assign activation_min = r_amin;
endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Directed bench for the M=2, N=4 layer: inference, learn, clamp/saturation, handshake and reset abort.
module tb_neuron_learn_layer_seq;
  import neuron_learn_layer_seq_pkg::*;

  localparam int N = 4;
  localparam int M = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                learn = 1'b0;
  zero2one_t [N-1:0]   in_v = '0;
  zero2one_t [M-1:0]   exp_v = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  zero2one_t [M-1:0]   out_v;
  zero2one_t [N-1:0]   exp_in_v;
  frac_t [M-1:0][N-1:0] weights;
  frac_t [M-1:0]       amax;
  frac_t [M-1:0]       amin;
  logic                w_wr_en = 1'b0;
  logic [0:0]          w_wr_row = '0;
  logic [1:0]          w_wr_col = '0;
  frac_t               w_wr_data = '0;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int lat;

  neuron_learn_layer_seq #(.N(N), .M(M), .LR_SHIFT(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .learn          (learn),
    .in             (in_v),
    .expected_out   (exp_v),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out            (out_v),
    .expected_in    (exp_in_v),
    .weights        (weights),
    .activation_max (amax),
    .activation_min (amin),
    .w_wr_en        (w_wr_en),
    .w_wr_row       (w_wr_row),
    .w_wr_col       (w_wr_col),
    .w_wr_data      (w_wr_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wload(input int row, input int col, input int data);
    w_wr_en   = 1'b1;
    w_wr_row  = row[0:0];
    w_wr_col  = col[1:0];
    w_wr_data = frac_t'(data);
    tick();
    w_wr_en   = 1'b0;
  endtask

  task automatic start_tx(input logic lrn);
    learn    = lrn;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
  endtask

  task automatic wait_valid();
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic end_tx(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, out_valid, 0);
    check({tag, "_inready_back"}, in_ready, 1);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_w00", $signed(weights[0][0]), 0);
    check("rst_w13", $signed(weights[1][3]), 0);
    check("rst_amax0", $signed(amax[0]), -32768);
    check("rst_amin1", $signed(amin[1]), 32767);
    check("rst_out0", out_v[0], 0);
    check("rst_expin0", exp_in_v[0], 0);

    // Inference: row 0 = {1.0,0,0,0}, row 1 = 0.5 everywhere, inputs 100/256
    wload(0, 0, 16384);
    for (int c = 0; c < N; c++) wload(1, c, 8192);
    for (int k = 0; k < N; k++) in_v[k] = 8'd100;
    exp_v = '0;
    start_tx(1'b0);
    wait_valid();
    check("inf_latency", lat, 9);
    check("inf_out0", out_v[0], 100);
    check("inf_out1", out_v[1], 200);
    for (int k = 0; k < N; k++) check("inf_expin", exp_in_v[k], 100);
    check("inf_amax0", $signed(amax[0]), 6400);
    check("inf_amax1", $signed(amax[1]), 12800);
    check("inf_amin0", $signed(amin[0]), 6400);
    check("inf_amin1", $signed(amin[1]), 12800);

    // Downstream stalls for 5 cycles while a new transaction is offered
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_out0", out_v[0], 100);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    end_tx("inf");

    // Learn: err = {50, 0}, delta = (50*100)>>>6 = 78 on row 0
    exp_v[0] = 8'd150;
    exp_v[1] = 8'd200;
    start_tx(1'b1);
    wait_valid();
    check("lrn_latency", lat, 17);
    check("lrn_out0", out_v[0], 100);
    check("lrn_w00", $signed(weights[0][0]), 16462);
    for (int c = 1; c < N; c++) check("lrn_w0c", $signed(weights[0][c]), 78);
    for (int c = 0; c < N; c++) check("lrn_w1c", $signed(weights[1][c]), 8192);
    check("lrn_expin0", exp_in_v[0], 125);
    for (int k = 1; k < N; k++) check("lrn_expin", exp_in_v[k], 100);
    end_tx("lrn");

    // Output clamps high: 4 * 1.0 * 100/256 -> 400, clamped to 255
    for (int c = 0; c < N; c++) wload(0, c, 16384);
    start_tx(1'b0);
    wait_valid();
    check("clamp_out0", out_v[0], 255);
    check("clamp_out1", out_v[1], 200);
    check("clamp_amax0", $signed(amax[0]), 25600);
    check("clamp_amin0", $signed(amin[0]), 6400);
    end_tx("clamp");

    // Weight at FRAC_MAX with positive error stays saturated
    wload(0, 0, 32767);
    for (int c = 1; c < N; c++) wload(0, c, 0);
    in_v = '0;
    in_v[0] = 8'd100;
    exp_v[0] = 8'd255;
    exp_v[1] = 8'd50;
    start_tx(1'b1);
    wait_valid();
    check("sat_out0", out_v[0], 199);
    check("sat_out1", out_v[1], 50);
    check("sat_w00", $signed(weights[0][0]), 32767);
    check("sat_w01", $signed(weights[0][1]), 0);
    check("sat_expin0", exp_in_v[0], 155);
    check("sat_expin1", exp_in_v[1], 0);
    end_tx("sat");

    // Negative pre-activation clamps to 0; a weight write during MAC is ignored
    wload(0, 0, -16384);
    start_tx(1'b0);
    tick();
    tick();
    lat = 2;
    w_wr_en   = 1'b1;
    w_wr_row  = 1'b1;
    w_wr_col  = 2'd0;
    w_wr_data = frac_t'(1234);
    tick();
    lat++;
    w_wr_en = 1'b0;
    wait_valid();
    check("neg_latency", lat, 9);
    check("neg_out0", out_v[0], 0);
    check("neg_out1", out_v[1], 50);
    check("neg_amin0", $signed(amin[0]), -6400);
    check("midmac_w10", $signed(weights[1][0]), 8192);
    end_tx("neg");

    // Reset lands on cycle 12 of a learn transaction (inside UPDATE)
    start_tx(1'b1);
    for (int c = 1; c < 12; c++) tick();
    check("pre_rst_in_ready", in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_w00", $signed(weights[0][0]), 0);
    check("abort_w10", $signed(weights[1][0]), 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_amax0", $signed(amax[0]), -32768);
    check("abort_out1", out_v[1], 0);
    tick();
    check("abort_stays_idle", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
